// File: rtl/collision_detector_pkg.sv
// Shared definitions for the bullet/alien collision scanner: default sizing,
// coordinate width and the scan state encoding.
package collision_detector_pkg;

    localparam int NUM_ALIENS_DEF   = 8;
    localparam int SCORE_W_DEF      = 16;
    localparam int ALIEN_POINTS_DEF = 10;
    localparam int COORD_W          = 12;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } scan_state_e;

    // Index width that stays legal for a single alien.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/collision_detector_aabb_overlap.sv
// Inclusive axis-aligned bounding box overlap test on signed coordinates.
// Touching edges count as overlap. Purely combinational so it can be shared
// by any scanner that time-multiplexes boxes through it.
module aabb_overlap
    import collision_detector_pkg::*;
(
    input  logic signed [COORD_W-1:0] a_lhpos,
    input  logic signed [COORD_W-1:0] a_rhpos,
    input  logic signed [COORD_W-1:0] a_tvpos,
    input  logic signed [COORD_W-1:0] a_bvpos,
    input  logic signed [COORD_W-1:0] b_lhpos,
    input  logic signed [COORD_W-1:0] b_rhpos,
    input  logic signed [COORD_W-1:0] b_tvpos,
    input  logic signed [COORD_W-1:0] b_bvpos,
    output logic                      overlap
);

    assign overlap = (a_lhpos <= b_rhpos) && (b_lhpos <= a_rhpos) &&
                     (a_tvpos <= b_bvpos) && (b_tvpos <= a_bvpos);

endmodule

// File: rtl/collision_detector.sv
// Frame-rate collision scanner: once per fsync, walks every alien through a
// single shared box comparator, records the lowest-index live alien hit by
// the bullet, then publishes a one-hot hit vector, a bullet retire pulse and
// a saturating score. A frame strobe arriving mid-scan abandons the partial
// result, flags a sticky overrun and restarts the scan.
module collision_detector
    import collision_detector_pkg::*;
#(
    parameter int NUM_ALIENS   = NUM_ALIENS_DEF,
    parameter int SCORE_W      = SCORE_W_DEF,
    parameter int ALIEN_POINTS = ALIEN_POINTS_DEF
) (
    input  logic                      pixel_clk,
    input  logic                      rst,
    input  logic                      fsync,
    input  logic                      bullet_active,
    input  logic signed [COORD_W-1:0] bullet_lhpos,
    input  logic signed [COORD_W-1:0] bullet_rhpos,
    input  logic signed [COORD_W-1:0] bullet_tvpos,
    input  logic signed [COORD_W-1:0] bullet_bvpos,
    input  logic [NUM_ALIENS-1:0]     alien_alive,
    input  logic signed [COORD_W-1:0] alien_lhpos [0:NUM_ALIENS-1],
    input  logic signed [COORD_W-1:0] alien_rhpos [0:NUM_ALIENS-1],
    input  logic signed [COORD_W-1:0] alien_tvpos [0:NUM_ALIENS-1],
    input  logic signed [COORD_W-1:0] alien_bvpos [0:NUM_ALIENS-1],
    output logic [NUM_ALIENS-1:0]     alien_hit,
    output logic                      bullet_hit,
    output logic [SCORE_W-1:0]        score,
    output logic                      scan_busy,
    output logic                      overrun
);

    localparam int                  IDX_W      = idx_width(NUM_ALIENS);
    localparam logic [IDX_W-1:0]    LAST_IDX   = IDX_W'(NUM_ALIENS - 1);
    localparam logic [SCORE_W:0]    POINTS_EXT = (SCORE_W + 1)'(ALIEN_POINTS);

    scan_state_e             state_q,      state_d;
    logic [IDX_W-1:0]        idx_q,        idx_d;
    logic                    found_q,      found_d;
    logic [IDX_W-1:0]        hit_idx_q,    hit_idx_d;
    logic [NUM_ALIENS-1:0]   alien_hit_q,  alien_hit_d;
    logic                    bullet_hit_q, bullet_hit_d;
    logic [SCORE_W-1:0]      score_q,      score_d;
    logic                    scan_busy_q,  scan_busy_d;
    logic                    overrun_q,    overrun_d;

    logic signed [COORD_W-1:0] sel_lhpos_s;
    logic signed [COORD_W-1:0] sel_rhpos_s;
    logic signed [COORD_W-1:0] sel_tvpos_s;
    logic signed [COORD_W-1:0] sel_bvpos_s;
    logic                      sel_alive_s;
    logic                      overlap_s;
    logic                      candidate_s;
    logic [NUM_ALIENS-1:0]     onehot_s;
    logic [SCORE_W:0]          score_sum_s;
    logic [SCORE_W-1:0]        score_sat_s;

    // Select the alien under test; boxes are stable because they only move on fsync.
    always_comb begin
        sel_lhpos_s = alien_lhpos[idx_q];
        sel_rhpos_s = alien_rhpos[idx_q];
        sel_tvpos_s = alien_tvpos[idx_q];
        sel_bvpos_s = alien_bvpos[idx_q];
        sel_alive_s = alien_alive[idx_q];
    end

    aabb_overlap u_overlap (
        .a_lhpos (bullet_lhpos),
        .a_rhpos (bullet_rhpos),
        .a_tvpos (bullet_tvpos),
        .a_bvpos (bullet_bvpos),
        .b_lhpos (sel_lhpos_s),
        .b_rhpos (sel_rhpos_s),
        .b_tvpos (sel_tvpos_s),
        .b_bvpos (sel_bvpos_s),
        .overlap (overlap_s)
    );

    // Candidate qualification, one-hot decode and saturating score increment.
    always_comb begin
        candidate_s = sel_alive_s && bullet_active && overlap_s;
        onehot_s    = NUM_ALIENS'(1) << hit_idx_q;
        score_sum_s = {1'b0, score_q} + POINTS_EXT;
        if (score_sum_s[SCORE_W]) begin
            score_sat_s = '1;
        end else begin
            score_sat_s = score_sum_s[SCORE_W-1:0];
        end
    end

    // Scan sequencing: next-state and next-output computation.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        found_d      = found_q;
        hit_idx_d    = hit_idx_q;
        alien_hit_d  = alien_hit_q;
        bullet_hit_d = 1'b0;
        score_d      = score_q;
        overrun_d    = overrun_q;

        case (state_q)
            ST_IDLE: begin
                if (fsync) begin
                    state_d = ST_SCAN;
                    idx_d   = '0;
                    found_d = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SCAN: begin
                if (fsync) begin
                    // Late frame strobe: drop this scan and start over.
                    overrun_d = 1'b1;
                    idx_d     = '0;
                    found_d   = 1'b0;
                end else begin
                    if (candidate_s && !found_q) begin
                        found_d   = 1'b1;
                        hit_idx_d = idx_q;
                    end else begin
                        found_d   = found_q;
                    end
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            ST_DONE: begin
                if (fsync) begin
                    // Result not yet published, so it is abandoned too.
                    overrun_d = 1'b1;
                    state_d   = ST_SCAN;
                    idx_d     = '0;
                    found_d   = 1'b0;
                end else begin
                    alien_hit_d  = found_q ? onehot_s : '0;
                    bullet_hit_d = found_q;
                    if (found_q) begin
                        score_d = score_sat_s;
                    end else begin
                        score_d = score_q;
                    end
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
                found_d = 1'b0;
            end
        endcase

        scan_busy_d = (state_d == ST_SCAN);
    end

    // State and registered outputs, synchronous reset.
    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            found_q      <= 1'b0;
            hit_idx_q    <= '0;
            alien_hit_q  <= '0;
            bullet_hit_q <= 1'b0;
            score_q      <= '0;
            scan_busy_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            found_q      <= found_d;
            hit_idx_q    <= hit_idx_d;
            alien_hit_q  <= alien_hit_d;
            bullet_hit_q <= bullet_hit_d;
            score_q      <= score_d;
            scan_busy_q  <= scan_busy_d;
            overrun_q    <= overrun_d;
        end
    end

    assign alien_hit  = alien_hit_q;
    assign bullet_hit = bullet_hit_q;
    assign score      = score_q;
    assign scan_busy  = scan_busy_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_collision_detector.sv
// Scoreboard bench for collision_detector. A second instance with a large
// per-hit award shares all inputs to reach score saturation in a few frames.
module tb_collision_detector;

    localparam int N       = 8;
    localparam int SW      = 16;
    localparam int PTS     = 10;
    localparam int PTS_SAT = 10000;
    localparam int SMAX    = 65535;

    logic                    pixel_clk = 1'b0;
    logic                    rst;
    logic                    fsync;
    logic                    bullet_active;
    logic signed [11:0]      b_l, b_r, b_t, b_b;
    logic [N-1:0]            alive;
    logic signed [11:0]      a_l [0:N-1];
    logic signed [11:0]      a_r [0:N-1];
    logic signed [11:0]      a_t [0:N-1];
    logic signed [11:0]      a_b [0:N-1];

    logic [N-1:0]            alien_hit,  alien_hit_s2;
    logic                    bullet_hit, bullet_hit_s2;
    logic [SW-1:0]           score,      score_s2;
    logic                    scan_busy,  scan_busy_s2;
    logic                    overrun,    overrun_s2;

    collision_detector #(.NUM_ALIENS(N), .SCORE_W(SW), .ALIEN_POINTS(PTS)) dut (
        .pixel_clk(pixel_clk), .rst(rst), .fsync(fsync), .bullet_active(bullet_active),
        .bullet_lhpos(b_l), .bullet_rhpos(b_r), .bullet_tvpos(b_t), .bullet_bvpos(b_b),
        .alien_alive(alive), .alien_lhpos(a_l), .alien_rhpos(a_r),
        .alien_tvpos(a_t), .alien_bvpos(a_b),
        .alien_hit(alien_hit), .bullet_hit(bullet_hit), .score(score),
        .scan_busy(scan_busy), .overrun(overrun)
    );

    collision_detector #(.NUM_ALIENS(N), .SCORE_W(SW), .ALIEN_POINTS(PTS_SAT)) dut_sat (
        .pixel_clk(pixel_clk), .rst(rst), .fsync(fsync), .bullet_active(bullet_active),
        .bullet_lhpos(b_l), .bullet_rhpos(b_r), .bullet_tvpos(b_t), .bullet_bvpos(b_b),
        .alien_alive(alive), .alien_lhpos(a_l), .alien_rhpos(a_r),
        .alien_tvpos(a_t), .alien_bvpos(a_b),
        .alien_hit(alien_hit_s2), .bullet_hit(bullet_hit_s2), .score(score_s2),
        .scan_busy(scan_busy_s2), .overrun(overrun_s2)
    );

    always #5 pixel_clk = ~pixel_clk;

    typedef struct {
        string      tag;
        logic [N-1:0] hit;
        int         pulses;
        int         score;
        int         score_sat;
        logic       ovr;
    } exp_t;

    exp_t          sb [$];
    int            checks = 0;
    int            errors = 0;
    int            model_score = 0;
    int            model_score_sat = 0;
    logic [N-1:0]  model_last_hit = '0;
    logic          model_overrun = 1'b0;

    // Single comparison point for the whole bench.
    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_alien(input int i, input int l, input int r, input int t, input int b,
                             input logic alv);
        a_l[i] = 12'(l); a_r[i] = 12'(r); a_t[i] = 12'(t); a_b[i] = 12'(b);
        alive[i] = alv;
    endtask

    task automatic park_aliens();
        for (int i = 0; i < N; i++) set_alien(i, -500, -480, -500, -480, 1'b1);
    endtask

    task automatic set_bullet(input int l, input int r, input int t, input int b, input logic act);
        b_l = 12'(l); b_r = 12'(r); b_t = 12'(t); b_b = 12'(b);
        bullet_active = act;
    endtask

    // Reference: lowest-index live alien whose inclusive box meets the bullet.
    function automatic logic [N-1:0] model_hit();
        logic [N-1:0] one;
        one = {{(N-1){1'b0}}, 1'b1};
        for (int i = 0; i < N; i++) begin
            if (alive[i] && bullet_active &&
                (b_l <= a_r[i]) && (a_l[i] <= b_r) && (b_t <= a_b[i]) && (a_t[i] <= b_b))
                return one << i;
        end
        return '0;
    endfunction

    function automatic int sat_add(input int s, input int p);
        return (s + p > SMAX) ? SMAX : s + p;
    endfunction

    // One frame: push expectation, strobe fsync (optionally again after
    // restart_at cycles), count bullet_hit pulses, then pop and compare.
    task automatic run_frame(input string tag, input logic [N-1:0] exp_hit, input int restart_at);
        exp_t e;
        int   pulses;
        if (exp_hit != '0) begin
            model_score     = sat_add(model_score, PTS);
            model_score_sat = sat_add(model_score_sat, PTS_SAT);
        end
        if (restart_at > 0) model_overrun = 1'b1;
        e.tag = tag; e.hit = exp_hit; e.pulses = (exp_hit != '0) ? 1 : 0;
        e.score = model_score; e.score_sat = model_score_sat; e.ovr = model_overrun;
        sb.push_back(e);

        fsync = 1'b1;
        @(posedge pixel_clk);
        @(negedge pixel_clk);
        fsync = 1'b0;
        check_eq({tag, "_hold"}, alien_hit, model_last_hit);
        check_eq({tag, "_busy"}, scan_busy, 1'b1);
        pulses = bullet_hit ? 1 : 0;
        if (restart_at > 0) begin
            for (int k = 1; k < restart_at; k++) begin
                @(posedge pixel_clk);
                @(negedge pixel_clk);
                if (bullet_hit) pulses++;
            end
            fsync = 1'b1;
            @(posedge pixel_clk);
            @(negedge pixel_clk);
            fsync = 1'b0;
            if (bullet_hit) pulses++;
            check_eq({tag, "_ovr_now"}, overrun, 1'b1);
        end
        for (int k = 1; k <= N + 2; k++) begin
            @(posedge pixel_clk);
            @(negedge pixel_clk);
            if (bullet_hit) pulses++;
        end

        e = sb.pop_front();
        check_eq({e.tag, "_alien_hit"}, alien_hit, e.hit);
        check_eq({e.tag, "_pulses"}, pulses, e.pulses);
        check_eq({e.tag, "_score"}, score, e.score);
        check_eq({e.tag, "_score_sat"}, score_s2, e.score_sat);
        check_eq({e.tag, "_overrun"}, overrun, e.ovr);
        check_eq({e.tag, "_idle"}, scan_busy, 1'b0);
        model_last_hit = e.hit;
    endtask

    initial begin
        rst = 1'b1; fsync = 1'b0;
        park_aliens();
        set_bullet(0, 0, 0, 0, 1'b0);
        repeat (3) @(posedge pixel_clk);
        @(negedge pixel_clk);
        rst = 1'b0;
        check_eq("rst_alien_hit", alien_hit, '0);
        check_eq("rst_bullet_hit", bullet_hit, 1'b0);
        check_eq("rst_score", score, '0);
        check_eq("rst_busy", scan_busy, 1'b0);
        check_eq("rst_overrun", overrun, 1'b0);

        // 1: every alien overlaps but bullet inactive.
        for (int i = 0; i < N; i++) set_alien(i, 100, 132, 100, 124, 1'b1);
        set_bullet(120, 122, 110, 118, 1'b0);
        run_frame("inactive", 8'b0000_0000, 0);

        // 2: single hit on alien 3.
        park_aliens();
        set_alien(3, 100, 132, 100, 124, 1'b1);
        set_bullet(120, 122, 110, 118, 1'b1);
        run_frame("single", 8'b0000_1000, 0);

        // 3: aliens 2 and 5 both overlap, lowest wins (hold of 0x08 checked at fsync).
        park_aliens();
        set_alien(2, 100, 132, 100, 124, 1'b1);
        set_alien(5, 110, 140, 105, 120, 1'b1);
        run_frame("priority", 8'b0000_0100, 0);

        // 4: touching right edge hits, one pixel past misses.
        park_aliens();
        set_alien(6, 100, 132, 100, 124, 1'b1);
        set_bullet(132, 134, 110, 118, 1'b1);
        run_frame("touch", 8'b0100_0000, 0);
        set_bullet(133, 135, 110, 118, 1'b1);
        run_frame("gap", 8'b0000_0000, 0);

        // 5: overlapping but dead alien.
        set_alien(6, 100, 132, 100, 124, 1'b0);
        set_bullet(120, 122, 110, 118, 1'b1);
        run_frame("dead", 8'b0000_0000, 0);

        // 6: fsync 3 cycles into a scan restarts it.
        park_aliens();
        set_alien(1, 100, 132, 100, 124, 1'b1);
        run_frame("restart", 8'b0000_0010, 3);

        // Saturation: large-award instance tops out and stays.
        for (int f = 0; f < 4; f++) run_frame("sat", 8'b0000_0010, 0);

        // Randomised frames checked against the reference model.
        for (int f = 0; f < 6; f++) begin
            int bl, bt;
            for (int i = 0; i < N; i++) begin
                int l, t;
                l = $urandom_range(0, 150);
                t = $urandom_range(0, 150);
                set_alien(i, l, l + $urandom_range(0, 32), t, t + $urandom_range(0, 24),
                          1'($urandom_range(0, 1)));
            end
            bl = $urandom_range(0, 180);
            bt = $urandom_range(0, 180);
            set_bullet(bl, bl + $urandom_range(0, 4), bt, bt + $urandom_range(0, 8), 1'b1);
            run_frame("rand", model_hit(), 0);
        end

        // Reset in the middle of a scan clears everything.
        fsync = 1'b1;
        @(posedge pixel_clk);
        @(negedge pixel_clk);
        fsync = 1'b0;
        repeat (3) @(posedge pixel_clk);
        @(negedge pixel_clk);
        rst = 1'b1;
        @(posedge pixel_clk);
        @(negedge pixel_clk);
        rst = 1'b0;
        check_eq("midrst_score", score, '0);
        check_eq("midrst_score_sat", score_s2, '0);
        check_eq("midrst_overrun", overrun, 1'b0);
        check_eq("midrst_alien_hit", alien_hit, '0);
        check_eq("midrst_busy", scan_busy, 1'b0);
        repeat (N + 3) begin
            @(posedge pixel_clk);
            @(negedge pixel_clk);
            check_eq("midrst_no_pulse", bullet_hit, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/collision_detector.md
Name: collision_detector

Overview:
- Produces the per-alien hit strobes consumed by the alien instances: `alien_hit_external` is fed from `alien_hit[i]`.
- Compares the player bullet's bounding box against every live alien's bounding box once per frame, using a sequential scan with one shared comparator.
- Retires the bullet on a hit and keeps the running score.
- Sits between the bullet and alien blocks in the game top level. All frame-rate logic is qualified by `fsync`.

Parameters:
- NUM_ALIENS, 8, number of alien instances scanned; range 1..64.
- SCORE_W, 16, score counter width.
- ALIEN_POINTS, 10, score added per alien destroyed.

Ports:
- pixel_clk  input  1  pixel clock.
- rst  input  1  synchronous, active-high reset; clock pixel_clk.
- fsync  input  1  one-cycle frame strobe; same strobe the aliens use.
- bullet_active  input  1  bullet in flight; no hits when 0.
- bullet_lhpos, bullet_rhpos, bullet_tvpos, bullet_bvpos  input  12 signed each  bullet bounding box, inclusive.
- alien_alive  input  NUM_ALIENS  per-alien alive flags.
- alien_lhpos, alien_rhpos, alien_tvpos, alien_bvpos  input  12 signed x NUM_ALIENS (unpacked [0:NUM_ALIENS-1])  alien bounding boxes, inclusive.
- alien_hit  output  NUM_ALIENS  one-hot or zero hit vector, held for one frame.
- bullet_hit  output  1  one-cycle pulse at scan end when a hit occurred.
- score  output  SCORE_W  accumulated score; saturates.
- scan_busy  output  1  high while in SCAN.
- overrun  output  1  sticky; set when fsync arrives during SCAN.

Behaviour:
- Reset values: all outputs 0; state IDLE; index 0.
- Overlap test is inclusive on both axes: A.l<=B.r && B.l<=A.r && A.t<=B.b && B.t<=A.b, compared as signed 12-bit. Touching edges count as a hit.
- Candidate i = alien_alive[i] && bullet_active && overlap(bullet, alien i).
- States:
  - IDLE: on fsync, go to SCAN with idx=0 and found=0.
  - SCAN: evaluate alien idx this cycle.
    - If candidate and !found: found<=1, hit_idx<=idx.
    - Only the lowest-index candidate is recorded; the bullet destroys at most one alien per frame.
    - idx increments each cycle. After idx==NUM_ALIENS-1, go to DONE.
    - Scan length is exactly NUM_ALIENS cycles.
  - DONE (one cycle):
    - alien_hit <= found ? onehot(hit_idx) : 0.
    - bullet_hit <= found (pulse).
    - If found: score += ALIEN_POINTS, saturating at all-ones.
    - Then go to IDLE.
- Latency: alien_hit becomes valid NUM_ALIENS+2 cycles after fsync. It holds until the next DONE, so it is stable at the next fsync edge, where the aliens sample it (one-frame latency).
- Boxes are read live during SCAN. They are stable because aliens and bullet update only on fsync.
- fsync while in SCAN or DONE:
  - Set overrun.
  - Abandon the partial result; alien_hit keeps its old value.
  - Restart SCAN at idx=0 with found=0.
- fsync in IDLE is the normal start. bullet_hit must not pulse on an abandoned scan.
- alien_alive[i]=0 is never a candidate, so a dead alien is never hit again.
- Reset mid-scan returns to IDLE and clears score, overrun and alien_hit.

Decomposition:
- Add to `params`: NUM_ALIENS, ALIEN_POINTS, SCORE_W defaults, and the 2-bit scan state enum typedef (IDLE/SCAN/DONE).
- One combinational sub-module, `aabb_overlap`: two inclusive signed boxes in, 1-bit overlap out. The bullet/alien tile collision logic reuses it later.
- Index mux, FSM and score logic stay in `collision_detector`.

Test Plan:
1. Reset, then fsync with bullet_active=0 and all boxes overlapping -> after NUM_ALIENS+2 cycles alien_hit=0, bullet_hit never pulses, score=0.
2. Alien 3 box (100,132,100,124) alive; bullet (120,122,110,118) active; fsync -> alien_hit=8'b0000_1000 at cycle NUM_ALIENS+2, single bullet_hit pulse, score=10. alien_hit still set at the next fsync edge.
3. Aliens 2 and 5 both overlap the bullet -> alien_hit=8'b0000_0100 only, score +10 once.
4. Edge touch: bullet_lhpos=132 equals alien rhpos=132, vertical overlap -> hit. Bullet_lhpos=133 -> no hit.
5. Overlapping alien with alien_alive=0 -> no hit, score unchanged.
6. Second fsync 3 cycles after the first (NUM_ALIENS=8) -> overrun=1, scan restarts, exactly one bullet_hit after the second scan. Then score preset near max (65530) plus one hit -> score=65535 and stays at 65535 after further hits.
